// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: multi-cycle 3x3 matrix ALU (add, sub, scalar mul, matrix mul, transpose, det)
// Latency: N edges from accept to out_valid (1, 9 or 27 depending on sel); one idle bubble after each result
// Backpressure: result held in DONE until out_ready; in_ready is low in RUN and DONE, and offered bundles are not queued
//
// Ports:
//   clk, reset            rising-edge clock, async active-low reset
//   in_valid/in_ready     operand handshake; sel, c, mat_a, mat_b sampled on accept
//   out_valid/out_ready   result handshake; mat_out, determinant, err held while out_valid
//   busy                  high while an operation is running or its result is pending
//   Matrices are row-major with element 00 in the MSBs and element 22 in the LSBs.
module matrix_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         sel,
   input  logic [WIDTH-1:0]   c,
   input  logic [9*WIDTH-1:0] mat_a,
   input  logic [9*WIDTH-1:0] mat_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [9*WIDTH-1:0] mat_out,
   output logic [WIDTH-1:0]   determinant,
   output logic               err,
   output logic               busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_SCALE = 3'd2;
   localparam logic [2:0] OP_MMUL  = 3'd3;
   localparam logic [2:0] OP_TRANS = 3'd4;
   localparam logic [2:0] OP_DET   = 3'd5;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] a_q [9];
   logic [WIDTH-1:0] a_d [9];
   logic [WIDTH-1:0] b_q [9];
   logic [WIDTH-1:0] b_d [9];
   // working matrix: filled element by element, copied to mat_q on the last RUN edge
   logic [WIDTH-1:0] w_q [9];
   logic [WIDTH-1:0] w_d [9];
   logic [WIDTH-1:0] mat_q [9];
   logic [WIDTH-1:0] mat_d [9];
   // determinant partial products: ei, fh, di, fg, dh, eg
   logic [WIDTH-1:0] p_q [6];
   logic [WIDTH-1:0] p_d [6];
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] det_q, det_d;
   logic             err_q, err_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [1:0]       i_q, i_d, j_q, j_d, k_q, k_d;

   logic [WIDTH-1:0] mul_x, mul_y, mul_p;
   logic [WIDTH-1:0] mm_sum;
   logic             last;

   function automatic logic [3:0] idx(input logic [1:0] r, input logic [1:0] col);
      return {2'b00, r} * 4'd3 + {2'b00, col};
   endfunction

   // the single shared multiplier; product truncated to WIDTH bits (modulo 2^WIDTH)
   assign mul_p = mul_x * mul_y;

   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (sel_q)
         OP_SCALE: begin
            mul_x = c_q;
            mul_y = a_q[cnt_q[3:0]];
         end
         OP_MMUL: begin
            mul_x = a_q[idx(i_q, k_q)];
            mul_y = b_q[idx(k_q, j_q)];
         end
         OP_DET: begin
            // a..i = a_q[0]..a_q[8]
            case (cnt_q)
               5'd0: begin mul_x = a_q[4]; mul_y = a_q[8]; end
               5'd1: begin mul_x = a_q[5]; mul_y = a_q[7]; end
               5'd2: begin mul_x = a_q[3]; mul_y = a_q[8]; end
               5'd3: begin mul_x = a_q[5]; mul_y = a_q[6]; end
               5'd4: begin mul_x = a_q[3]; mul_y = a_q[7]; end
               5'd5: begin mul_x = a_q[4]; mul_y = a_q[6]; end
               5'd6: begin mul_x = a_q[0]; mul_y = p_q[0] - p_q[1]; end
               5'd7: begin mul_x = a_q[1]; mul_y = p_q[2] - p_q[3]; end
               5'd8: begin mul_x = a_q[2]; mul_y = p_q[4] - p_q[5]; end
               default: begin mul_x = '0; mul_y = '0; end
            endcase
         end
         default: begin
            mul_x = '0;
            mul_y = '0;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      w_d     = w_q;
      mat_d   = mat_q;
      p_d     = p_q;
      acc_d   = acc_q;
      det_d   = det_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      mm_sum  = '0;
      last    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               sel_d = sel;
               c_d   = c;
               for (int n = 0; n < 9; n++) begin
                  a_d[n] = mat_a[(8-n)*WIDTH +: WIDTH];
                  b_d[n] = mat_b[(8-n)*WIDTH +: WIDTH];
               end
               cnt_d   = '0;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            cnt_d = cnt_q + 5'd1;
            case (sel_q)
               OP_ADD: begin
                  for (int n = 0; n < 9; n++) w_d[n] = a_q[n] + b_q[n];
                  last = 1'b1;
               end
               OP_SUB: begin
                  for (int n = 0; n < 9; n++) w_d[n] = a_q[n] - b_q[n];
                  last = 1'b1;
               end
               OP_SCALE: begin
                  w_d[cnt_q[3:0]] = mul_p;
                  last = (cnt_q == 5'd8);
               end
               OP_MMUL: begin
                  // accumulator restarts at k=0, so no separate clear cycle is needed
                  mm_sum = ((k_q == 2'd0) ? '0 : acc_q) + mul_p;
                  acc_d  = mm_sum;
                  if (k_q == 2'd2) begin
                     w_d[idx(i_q, j_q)] = mm_sum;
                     k_d = 2'd0;
                     if (j_q == 2'd2) begin
                        j_d = 2'd0;
                        i_d = i_q + 2'd1;
                     end else begin
                        j_d = j_q + 2'd1;
                     end
                  end else begin
                     k_d = k_q + 2'd1;
                  end
                  last = (cnt_q == 5'd26);
               end
               OP_TRANS: begin
                  for (int r = 0; r < 3; r++)
                     for (int col = 0; col < 3; col++)
                        w_d[r*3+col] = a_q[col*3+r];
                  last = 1'b1;
               end
               OP_DET: begin
                  for (int n = 0; n < 9; n++) w_d[n] = '0;
                  if (cnt_q < 5'd6) begin
                     p_d[cnt_q[2:0]] = mul_p;
                  end else if (cnt_q == 5'd6) begin
                     acc_d = mul_p;
                  end else if (cnt_q == 5'd7) begin
                     acc_d = acc_q - mul_p;
                  end else begin
                     det_d = acc_q + mul_p;
                     last  = 1'b1;
                  end
               end
               default: begin
                  for (int n = 0; n < 9; n++) w_d[n] = '0;
                  last = 1'b1;
               end
            endcase

            if (last) begin
               mat_d   = w_d;
               err_d   = (sel_q == 3'd6) || (sel_q == 3'd7);
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         c_q     <= '0;
         for (int n = 0; n < 9; n++) begin
            a_q[n]   <= '0;
            b_q[n]   <= '0;
            w_q[n]   <= '0;
            mat_q[n] <= '0;
         end
         for (int n = 0; n < 6; n++) p_q[n] <= '0;
         acc_q <= '0;
         det_q <= '0;
         err_q <= 1'b0;
         cnt_q <= '0;
         i_q   <= '0;
         j_q   <= '0;
         k_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         w_q     <= w_d;
         mat_q   <= mat_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         det_q   <= det_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign out_valid   = (state_q == ST_DONE);
   assign busy        = (state_q != ST_IDLE);
   assign determinant = det_q;
   assign err         = err_q;

   for (genvar g = 0; g < 9; g++) begin : g_pack
      assign mat_out[(8-g)*WIDTH +: WIDTH] = mat_q[g];
   end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb_matrix_alu_seq: directed table-driven bench for matrix_alu_seq (WIDTH=32)
// Latency: each vector's out_valid edge count is checked against its hand-computed N
// Backpressure: hand-written sequences hold out_ready low and assert reset mid-operation
module tb_matrix_alu_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [2:0]     sel;
   logic [W-1:0]   c;
   logic [9*W-1:0] mat_a;
   logic [9*W-1:0] mat_b;
   logic           out_valid;
   logic           out_ready;
   logic [9*W-1:0] mat_out;
   logic [W-1:0]   determinant;
   logic           err;
   logic           busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_alu_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .sel         (sel),
      .c           (c),
      .mat_a       (mat_a),
      .mat_b       (mat_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .mat_out     (mat_out),
      .determinant (determinant),
      .err         (err),
      .busy        (busy)
   );

   typedef struct {
      string          name;
      logic [2:0]     sel;
      logic [W-1:0]   c;
      logic [9*W-1:0] a;
      logic [9*W-1:0] b;
      logic [9*W-1:0] mat;
      logic [W-1:0]   det;
      logic           err;
      int             lat;
   } vec_t;

   vec_t tbl [10];

   function automatic logic [9*W-1:0] m9(input logic [W-1:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
      return {e0, e1, e2, e3, e4, e5, e6, e7, e8};
   endfunction

   function automatic vec_t mkv(input string nm, input logic [2:0] s, input logic [W-1:0] cc,
                                input logic [9*W-1:0] a, b, m, input logic [W-1:0] d,
                                input logic e, input int l);
      vec_t v;
      v.name = nm; v.sel = s; v.c = cc; v.a = a; v.b = b;
      v.mat = m; v.det = d; v.err = e; v.lat = l;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [9*W-1:0] act, input logic [9*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Offers one bundle, measures latency, checks results, then consumes it.
   task automatic run_vec(input vec_t v);
      int lat;
      @(negedge clk);
      sel = v.sel; c = v.c; mat_a = v.a; mat_b = v.b;
      in_valid = 1'b1; out_ready = 1'b0;
      chk({v.name, ".in_ready_idle"}, {287'd0, in_ready}, 288'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({v.name, ".latency"}, 288'(lat), 288'(v.lat));
      chk({v.name, ".mat_out"}, mat_out, v.mat);
      chk({v.name, ".determinant"}, 288'(determinant), 288'(v.det));
      chk({v.name, ".err"}, 288'(err), 288'(v.err));
      chk({v.name, ".in_ready_done"}, 288'(in_ready), 288'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({v.name, ".out_valid_after"}, 288'(out_valid), 288'd0);
      chk({v.name, ".in_ready_after"}, 288'(in_ready), 288'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9*W-1:0] seq19, zero9, all6;
      int lat;
      seq19 = m9(1, 2, 3, 4, 5, 6, 7, 8, 9);
      zero9 = '0;
      all6  = m9(6, 6, 6, 6, 6, 6, 6, 6, 6);

      tbl[0] = mkv("det", 3'd5, 0, m9(6, 1, 1, 4, -2, 5, 2, 8, 7), zero9, zero9, 32'hFFFFFECE, 1'b0, 9);
      tbl[1] = mkv("mmul", 3'd3, 0, seq19, seq19, m9(30, 36, 42, 66, 81, 96, 102, 126, 150),
                   32'hFFFFFECE, 1'b0, 27);
      tbl[2] = mkv("add_wrap", 3'd0, 0, m9(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0),
                   m9(1, 0, 0, 0, 0, 0, 0, 0, 0), zero9, 32'hFFFFFECE, 1'b0, 1);
      tbl[3] = mkv("sub_wrap", 3'd1, 0, m9(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0),
                   m9(1, 0, 0, 0, 0, 0, 0, 0, 0), m9(32'hFFFFFFFE, 0, 0, 0, 0, 0, 0, 0, 0),
                   32'hFFFFFECE, 1'b0, 1);
      tbl[4] = mkv("sub_neg", 3'd1, 0, seq19, m9(2, 2, 2, 2, 2, 2, 2, 2, 2),
                   m9(-1, 0, 1, 2, 3, 4, 5, 6, 7), 32'hFFFFFECE, 1'b0, 1);
      tbl[5] = mkv("illegal7", 3'd7, 0, seq19, seq19, zero9, 32'hFFFFFECE, 1'b1, 1);
      tbl[6] = mkv("trans_clr", 3'd4, 0, seq19, zero9, m9(1, 4, 7, 2, 5, 8, 3, 6, 9),
                   32'hFFFFFECE, 1'b0, 1);
      tbl[7] = mkv("scale5", 3'd2, 5, seq19, zero9, m9(5, 10, 15, 20, 25, 30, 35, 40, 45),
                   32'hFFFFFECE, 1'b0, 9);
      tbl[8] = mkv("illegal6", 3'd6, 0, seq19, zero9, zero9, 32'hFFFFFECE, 1'b1, 1);
      tbl[9] = mkv("det_neg3", 3'd5, 0, m9(1, 2, 3, 4, 5, 6, 7, 8, 10), zero9, zero9,
                   32'hFFFFFFFD, 1'b0, 9);

      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sel = '0; c = '0; mat_a = '0; mat_b = '0;
      #12;
      chk("reset.in_ready", 288'(in_ready), 288'd1);
      chk("reset.out_valid", 288'(out_valid), 288'd0);
      chk("reset.mat_out", mat_out, zero9);
      chk("reset.determinant", 288'(determinant), 288'd0);
      chk("reset.err", 288'(err), 288'd0);
      chk("reset.busy", 288'(busy), 288'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int t = 0; t < 10; t++) run_vec(tbl[t]);

      // backpressure: scalar result must hold while out_ready is low
      @(negedge clk);
      sel = 3'd2; c = 3; mat_a = m9(2, 2, 2, 2, 2, 2, 2, 2, 2); mat_b = '0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp.latency", 288'(lat), 288'd9);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp.out_valid_hold", 288'(out_valid), 288'd1);
         chk("bp.mat_out_hold", mat_out, all6);
         chk("bp.in_ready_low", 288'(in_ready), 288'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.out_valid_drop", 288'(out_valid), 288'd0);
      chk("bp.in_ready_rise", 288'(in_ready), 288'd1);

      // asynchronous reset ten cycles into a matrix multiply
      @(negedge clk);
      sel = 3'd3; mat_a = seq19; mat_b = seq19; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("rst.busy_before", 288'(busy), 288'd1);
      reset = 1'b0;
      #1;
      chk("rst.mat_out", mat_out, zero9);
      chk("rst.determinant", 288'(determinant), 288'd0);
      chk("rst.out_valid", 288'(out_valid), 288'd0);
      chk("rst.busy", 288'(busy), 288'd0);
      chk("rst.in_ready", 288'(in_ready), 288'd1);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         chk("rst.no_spurious_valid", 288'(out_valid), 288'd0);
      end
      run_vec(mkv("rst_trans", 3'd4, 0, seq19, zero9, m9(1, 4, 7, 2, 5, 8, 3, 6, 9), 0, 1'b0, 1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
